// File: rtl/butterfly_unit_radix4_dif_if.sv
//------------------------------------------------------------------------------
// Module   : butterfly_unit_radix4_dif_if
// Brief    : Data/handshake bundle for the radix-4 DIF butterfly.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface butterfly_unit_radix4_dif_if;
  logic               valid_in;
  logic               inv;
  logic               clr_ovf;
  logic signed [15:0] cos1, sin1, cos2, sin2, cos3, sin3;
  logic signed [15:0] x1_re, x1_im, x2_re, x2_im, x3_re, x3_im, x4_re, x4_im;
  logic               valid_out;
  logic               ovf;
  logic               ovf_sticky;
  logic signed [15:0] p1_re, p1_im, p2_re, p2_im, p3_re, p3_im, p4_re, p4_im;

  modport master (
    output valid_in, inv, clr_ovf,
    output cos1, sin1, cos2, sin2, cos3, sin3,
    output x1_re, x1_im, x2_re, x2_im, x3_re, x3_im, x4_re, x4_im,
    input  valid_out, ovf, ovf_sticky,
    input  p1_re, p1_im, p2_re, p2_im, p3_re, p3_im, p4_re, p4_im
  );

  modport slave (
    input  valid_in, inv, clr_ovf,
    input  cos1, sin1, cos2, sin2, cos3, sin3,
    input  x1_re, x1_im, x2_re, x2_im, x3_re, x3_im, x4_re, x4_im,
    output valid_out, ovf, ovf_sticky,
    output p1_re, p1_im, p2_re, p2_im, p3_re, p3_im, p4_re, p4_im
  );
endinterface

`default_nettype wire

// File: rtl/butterfly_unit_radix4_dif.sv
//------------------------------------------------------------------------------
// Module   : butterfly_unit_radix4_dif
// Brief    : 5-stage radix-4 DIF butterfly (add/sub, then twiddle multiply).
//            Define BFLY_R4_DIF_SCALE_EN to divide the adder results by 4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module butterfly_unit_radix4_dif (
  input  wire logic                  clk,
  input  wire logic                  rst,
  butterfly_unit_radix4_dif_if.slave bus
);

  function automatic logic signed [17:0] f_scale(input logic signed [17:0] v);
`ifdef BFLY_R4_DIF_SCALE_EN
    return (v + 18'sd2) >>> 2;
`else
    return v;
`endif
  endfunction

  // Returns {saturated, value}
  function automatic logic [16:0] f_sat18(input logic signed [17:0] v);
    if (v > 18'sd32767)       return {1'b1, 16'h7FFF};
    else if (v < -18'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, 16'(v)};
  endfunction

  // S1 registers
  logic               r_s1_valid, r_s1_inv;
  logic signed [15:0] r_s1_xr [4];
  logic signed [15:0] r_s1_xi [4];
  logic signed [15:0] r_s1_wc [3];
  logic signed [15:0] r_s1_ws [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_s1_xr[k] <= '0;
        r_s1_xi[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        r_s1_wc[k] <= '0;
        r_s1_ws[k] <= '0;
      end
    end else begin
      r_s1_valid <= bus.valid_in;
      r_s1_inv   <= bus.inv;
      r_s1_xr[0] <= bus.x1_re;  r_s1_xi[0] <= bus.x1_im;
      r_s1_xr[1] <= bus.x2_re;  r_s1_xi[1] <= bus.x2_im;
      r_s1_xr[2] <= bus.x3_re;  r_s1_xi[2] <= bus.x3_im;
      r_s1_xr[3] <= bus.x4_re;  r_s1_xi[3] <= bus.x4_im;
      r_s1_wc[0] <= bus.cos1;   r_s1_ws[0] <= bus.sin1;
      r_s1_wc[1] <= bus.cos2;   r_s1_ws[1] <= bus.sin2;
      r_s1_wc[2] <= bus.cos3;   r_s1_ws[2] <= bus.sin3;
    end
  end

  // S2 adder: fwd = a-jb-c+jd, bwd = a+jb-c-jd
  logic signed [17:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
  logic signed [17:0] w_fwd_re, w_fwd_im, w_bwd_re, w_bwd_im;
  logic signed [17:0] w_sum_re [4];
  logic signed [17:0] w_sum_im [4];
  logic        [16:0] w_s2_re  [4];
  logic        [16:0] w_s2_im  [4];
  logic               w_s2_ovf;

  always_comb begin
    w_ar = 18'(r_s1_xr[0]);  w_ai = 18'(r_s1_xi[0]);
    w_br = 18'(r_s1_xr[1]);  w_bi = 18'(r_s1_xi[1]);
    w_cr = 18'(r_s1_xr[2]);  w_ci = 18'(r_s1_xi[2]);
    w_dr = 18'(r_s1_xr[3]);  w_di = 18'(r_s1_xi[3]);
    w_fwd_re = w_ar + w_bi - w_cr - w_di;
    w_fwd_im = w_ai - w_br - w_ci + w_dr;
    w_bwd_re = w_ar - w_bi - w_cr + w_di;
    w_bwd_im = w_ai + w_br - w_ci - w_dr;
    w_sum_re[0] = f_scale(w_ar + w_br + w_cr + w_dr);
    w_sum_im[0] = f_scale(w_ai + w_bi + w_ci + w_di);
    w_sum_re[1] = f_scale(r_s1_inv ? w_bwd_re : w_fwd_re);
    w_sum_im[1] = f_scale(r_s1_inv ? w_bwd_im : w_fwd_im);
    w_sum_re[2] = f_scale(w_ar - w_br + w_cr - w_dr);
    w_sum_im[2] = f_scale(w_ai - w_bi + w_ci - w_di);
    w_sum_re[3] = f_scale(r_s1_inv ? w_fwd_re : w_bwd_re);
    w_sum_im[3] = f_scale(r_s1_inv ? w_fwd_im : w_bwd_im);
    w_s2_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_s2_re[k] = f_sat18(w_sum_re[k]);
      w_s2_im[k] = f_sat18(w_sum_im[k]);
      w_s2_ovf   = w_s2_ovf | w_s2_re[k][16] | w_s2_im[k][16];
    end
  end

  // Sine kept at 17 bits so that negating -32768 for the inverse is exact
  logic               r_s2_valid, r_s2_ovf;
  logic signed [15:0] r_s2_yr [4];
  logic signed [15:0] r_s2_yi [4];
  logic signed [15:0] r_s2_wc [3];
  logic signed [16:0] r_s2_ws [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_ovf   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_s2_yr[k] <= '0;
        r_s2_yi[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        r_s2_wc[k] <= '0;
        r_s2_ws[k] <= '0;
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_ovf   <= w_s2_ovf;
      for (int k = 0; k < 4; k++) begin
        r_s2_yr[k] <= 16'(w_s2_re[k]);
        r_s2_yi[k] <= 16'(w_s2_im[k]);
      end
      for (int k = 0; k < 3; k++) begin
        r_s2_wc[k] <= r_s1_wc[k];
        r_s2_ws[k] <= r_s1_inv ? -17'(r_s1_ws[k]) : 17'(r_s1_ws[k]);
      end
    end
  end

  // S3 products, S4 round/shift, S5 saturate; y0 rides alongside
  logic               r_s3_valid, r_s3_ovf, r_s4_valid, r_s4_ovf, r_s5_valid, r_s5_ovf;
  logic signed [31:0] r_s3_prr [3];
  logic signed [31:0] r_s3_pii [3];
  logic signed [31:0] r_s3_pri [3];
  logic signed [31:0] r_s3_pir [3];
  logic signed [15:0] r_s3_y0r, r_s3_y0i, r_s4_y0r, r_s4_y0i;
  logic signed [17:0] r_s4_re [3];
  logic signed [17:0] r_s4_im [3];
  logic signed [15:0] r_s5_re [4];
  logic signed [15:0] r_s5_im [4];
  logic        [16:0] w_s5_re [3];
  logic        [16:0] w_s5_im [3];
  logic               w_s5_ovf;

  always_comb begin
    w_s5_ovf = r_s4_ovf;
    for (int k = 0; k < 3; k++) begin
      w_s5_re[k] = f_sat18(r_s4_re[k]);
      w_s5_im[k] = f_sat18(r_s4_im[k]);
      w_s5_ovf   = w_s5_ovf | w_s5_re[k][16] | w_s5_im[k][16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_s3_valid, r_s3_ovf, r_s4_valid, r_s4_ovf, r_s5_valid, r_s5_ovf} <= '0;
      {r_s3_y0r, r_s3_y0i, r_s4_y0r, r_s4_y0i} <= '0;
      for (int k = 0; k < 3; k++) begin
        r_s3_prr[k] <= '0;  r_s3_pii[k] <= '0;
        r_s3_pri[k] <= '0;  r_s3_pir[k] <= '0;
        r_s4_re[k]  <= '0;  r_s4_im[k]  <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        r_s5_re[k] <= '0;
        r_s5_im[k] <= '0;
      end
    end else begin
      r_s3_valid <= r_s2_valid;  r_s3_ovf <= r_s2_ovf;
      r_s4_valid <= r_s3_valid;  r_s4_ovf <= r_s3_ovf;
      r_s5_valid <= r_s4_valid;  r_s5_ovf <= w_s5_ovf;
      r_s3_y0r <= r_s2_yr[0];    r_s3_y0i <= r_s2_yi[0];
      r_s4_y0r <= r_s3_y0r;      r_s4_y0i <= r_s3_y0i;
      r_s5_re[0] <= r_s4_y0r;    r_s5_im[0] <= r_s4_y0i;
      for (int k = 0; k < 3; k++) begin
        r_s3_prr[k] <= 32'(33'(r_s2_yr[k+1]) * 33'(r_s2_wc[k]));
        r_s3_pii[k] <= 32'(33'(r_s2_yi[k+1]) * 33'(r_s2_ws[k]));
        r_s3_pri[k] <= 32'(33'(r_s2_yr[k+1]) * 33'(r_s2_ws[k]));
        r_s3_pir[k] <= 32'(33'(r_s2_yi[k+1]) * 33'(r_s2_wc[k]));
        r_s4_re[k]  <= 18'((33'(r_s3_prr[k]) - 33'(r_s3_pii[k]) + 33'sd16384) >>> 15);
        r_s4_im[k]  <= 18'((33'(r_s3_pri[k]) + 33'(r_s3_pir[k]) + 33'sd16384) >>> 15);
        r_s5_re[k+1] <= 16'(w_s5_re[k]);
        r_s5_im[k+1] <= 16'(w_s5_im[k]);
      end
    end
  end

  // Output registers hold between results; clr_ovf beats a simultaneous set
  logic               r_valid_out, r_ovf, r_ovf_sticky;
  logic signed [15:0] r_p_re [4];
  logic signed [15:0] r_p_im [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_out  <= 1'b0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_p_re[k] <= '0;
        r_p_im[k] <= '0;
      end
    end else begin
      r_valid_out <= r_s5_valid;
      r_ovf       <= r_s5_valid & r_s5_ovf;
      if (r_s5_valid) begin
        for (int k = 0; k < 4; k++) begin
          r_p_re[k] <= r_s5_re[k];
          r_p_im[k] <= r_s5_im[k];
        end
      end
      if (bus.clr_ovf)                 r_ovf_sticky <= 1'b0;
      else if (r_s5_valid && r_s5_ovf) r_ovf_sticky <= 1'b1;
    end
  end

  assign bus.valid_out  = r_valid_out;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.p1_re = r_p_re[0];  assign bus.p1_im = r_p_im[0];
  assign bus.p2_re = r_p_re[1];  assign bus.p2_im = r_p_im[1];
  assign bus.p3_re = r_p_re[2];  assign bus.p3_im = r_p_im[2];
  assign bus.p4_re = r_p_re[3];  assign bus.p4_im = r_p_im[3];

endmodule

`default_nettype wire
